// File: rtl/id_ex_forward_stage_pkg.sv
// rtl/id_ex_forward_stage_pkg.sv - shared constants for the ID/EX stage and its forwarding logic
// Contents:
//   fwd_sel_t       2-bit operand mux selector encoding
//   REG_ADDR_W      register-number width
//   CTRL_W_DEFAULT  default width of the opaque EX/MEM/WB control bundle
package id_ex_forward_stage_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int CTRL_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEMWB   = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forward_select.sv
// rtl/forward_select.sv - combinational comparator producing one operand forwarding selector
// Ports:
//   ex_valid         EX stage holds a real instruction
//   ex_src           source register number read by the EX instruction
//   exmem_reg_write  EX/MEM writes the register file
//   exmem_write_reg  EX/MEM destination register
//   memwb_reg_write  MEM/WB writes the register file
//   memwb_write_reg  MEM/WB destination register
//   sel              selector for the EX operand mux (never 2'b11)
module forward_select
  import id_ex_forward_stage_pkg::*;
(
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_src,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_write_reg,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_write_reg,
  output logic [1:0]            sel
);

  logic exmem_hit;
  logic memwb_hit;

  // $0 is hardwired to zero, so a write to it must never be forwarded.
  assign exmem_hit = ex_valid & exmem_reg_write & (exmem_write_reg != '0) &
                     (exmem_write_reg == ex_src);
  assign memwb_hit = ex_valid & memwb_reg_write & (memwb_write_reg != '0) &
                     (memwb_write_reg == ex_src);

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    sel = FWD_REGFILE;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// rtl/id_ex_forward_stage.sv - ID/EX pipeline register with load-use stall and forwarding selectors
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   flush                       kill the ID instruction (taken branch/jump)
//   id_*                        decoded instruction fields from the ID stage
//   exmem_*, memwb_*            destination info of the two older pipeline stages
//   ex_*                        registered EX-stage copies of the id_* fields
//   forward_a, forward_b        selectors for the ALU operand A/B muxes
//   stall                       hold PC and IF/ID (combinational)
module id_ex_forward_stage
  import id_ex_forward_stage_pkg::*;
#(
  parameter int NBits  = 32,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_write_reg,
  input  logic [NBits-1:0]      id_read_data1,
  input  logic [NBits-1:0]      id_read_data2,
  input  logic [NBits-1:0]      id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_write_reg,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_write_reg,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_write_reg,
  output logic [NBits-1:0]      ex_read_data1,
  output logic [NBits-1:0]      ex_read_data2,
  output logic [NBits-1:0]      ex_imm,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall
);

  logic hazard;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time; the ID instruction must wait one cycle.
  assign hazard = ex_valid & ex_mem_read & (ex_write_reg != '0) & id_valid &
                  ((ex_write_reg == id_rs) | (ex_write_reg == id_rt));

  // The ID instruction is being killed anyway, so there is nothing to hold.
  assign stall = hazard & ~flush;

  // Bubble insertion clears ex_mem_read, which is what limits the stall to
  // a single cycle per load-use pair.
  always_ff @(posedge clk) begin
    if (!reset || flush || stall) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_write_reg  <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm        <= '0;
      ex_ctrl       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
    end else begin
      ex_valid      <= id_valid;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_write_reg  <= id_write_reg;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_imm        <= id_imm;
      ex_ctrl       <= id_ctrl;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
    end
  end

  forward_select u_fwd_a (
    .ex_valid        (ex_valid),
    .ex_src          (ex_rs),
    .exmem_reg_write (exmem_reg_write),
    .exmem_write_reg (exmem_write_reg),
    .memwb_reg_write (memwb_reg_write),
    .memwb_write_reg (memwb_write_reg),
    .sel             (forward_a)
  );

  forward_select u_fwd_b (
    .ex_valid        (ex_valid),
    .ex_src          (ex_rt),
    .exmem_reg_write (exmem_reg_write),
    .exmem_write_reg (exmem_write_reg),
    .memwb_reg_write (memwb_reg_write),
    .memwb_write_reg (memwb_write_reg),
    .sel             (forward_b)
  );

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// tb/tb_id_ex_forward_stage.sv - directed self-checking bench for id_ex_forward_stage
module tb_id_ex_forward_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_write_reg;
  logic [31:0] id_read_data1, id_read_data2, id_imm;
  logic [7:0]  id_ctrl;
  logic        id_reg_write, id_mem_read;
  logic        exmem_reg_write;
  logic [4:0]  exmem_write_reg;
  logic        memwb_reg_write;
  logic [4:0]  memwb_write_reg;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic [31:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic        ex_reg_write, ex_mem_read;
  logic [1:0]  forward_a, forward_b;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_forward_stage #(.NBits(32), .CTRL_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_write_reg    (id_write_reg),
    .id_read_data1   (id_read_data1),
    .id_read_data2   (id_read_data2),
    .id_imm          (id_imm),
    .id_ctrl         (id_ctrl),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .exmem_reg_write (exmem_reg_write),
    .exmem_write_reg (exmem_write_reg),
    .memwb_reg_write (memwb_reg_write),
    .memwb_write_reg (memwb_write_reg),
    .ex_valid        (ex_valid),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_write_reg    (ex_write_reg),
    .ex_read_data1   (ex_read_data1),
    .ex_read_data2   (ex_read_data2),
    .ex_imm          (ex_imm),
    .ex_ctrl         (ex_ctrl),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .stall           (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, " ex_rs"}, {27'd0, ex_rs}, 32'd0);
    check({tag, " ex_write_reg"}, {27'd0, ex_write_reg}, 32'd0);
    check({tag, " ex_read_data1"}, ex_read_data1, 32'd0);
    check({tag, " ex_imm"}, ex_imm, 32'd0);
    check({tag, " ex_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
    check({tag, " ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
    check({tag, " forward_a"}, {30'd0, forward_a}, 32'd0);
    check({tag, " forward_b"}, {30'd0, forward_b}, 32'd0);
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic drive_load_9();
    id_valid = 1'b1; id_rs = 5'd4; id_rt = 5'd5; id_write_reg = 5'd9;
    id_mem_read = 1'b1; id_reg_write = 1'b1; id_ctrl = 8'h33;
  endtask

  task automatic drive_dependent();
    id_valid = 1'b1; id_rs = 5'd6; id_rt = 5'd9; id_write_reg = 5'd10;
    id_mem_read = 1'b0; id_reg_write = 1'b1; id_ctrl = 8'h77;
    id_read_data2 = 32'h0000_BEEF;
  endtask

  initial begin
    // Reset with busy ID inputs
    reset = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd7; id_write_reg = 5'd11;
    id_read_data1 = 32'hAAAA_5555; id_read_data2 = 32'h1111_2222; id_imm = 32'h0000_00FF;
    id_ctrl = 8'hC3; id_reg_write = 1'b1; id_mem_read = 1'b1;
    exmem_reg_write = 1'b0; exmem_write_reg = 5'd0;
    memwb_reg_write = 1'b0; memwb_write_reg = 5'd0;
    tick();
    check_all_zero("reset1");
    tick();
    check_all_zero("reset2");

    // Plain load, one-edge latency
    reset = 1'b1;
    id_read_data1 = 32'h0000_1234; id_rs = 5'd1; id_rt = 5'd2; id_write_reg = 5'd3;
    id_ctrl = 8'h5A; id_mem_read = 1'b0;
    tick();
    check("load ex_read_data1", ex_read_data1, 32'h0000_1234);
    check("load ex_ctrl", {24'd0, ex_ctrl}, 32'h5A);
    check("load ex_valid", {31'd0, ex_valid}, 32'd1);
    check("load ex_write_reg", {27'd0, ex_write_reg}, 32'd3);
    check("load ex_imm", ex_imm, 32'h0000_00FF);

    // Forwarding: ex_rs=8, ex_rt=0
    id_rs = 5'd8; id_rt = 5'd0;
    tick();
    check("fwd ex_rs", {27'd0, ex_rs}, 32'd8);
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd8;
    #1;
    check("fwd_a exmem", {30'd0, forward_a}, 32'b10);
    check("fwd_b no match", {30'd0, forward_b}, 32'b00);
    memwb_reg_write = 1'b1; memwb_write_reg = 5'd8;
    #1;
    check("fwd_a both match", {30'd0, forward_a}, 32'b10);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_a memwb", {30'd0, forward_a}, 32'b01);

    // $0 never forwarded
    memwb_reg_write = 1'b0;
    exmem_reg_write = 1'b1; exmem_write_reg = 5'd0;
    #1;
    check("fwd_b reg0", {30'd0, forward_b}, 32'b00);
    check("fwd_a reg0", {30'd0, forward_a}, 32'b00);
    exmem_reg_write = 1'b0;

    // Load-use stall
    drive_load_9();
    tick();
    check("lw in ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
    drive_dependent();
    #1;
    check("load-use stall", {31'd0, stall}, 32'd1);
    tick();
    check("bubble ex_valid", {31'd0, ex_valid}, 32'd0);
    check("bubble ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    check("bubble stall drop", {31'd0, stall}, 32'd0);
    tick();
    check("dep ex_rt", {27'd0, ex_rt}, 32'd9);
    check("dep ex_ctrl", {24'd0, ex_ctrl}, 32'h77);
    check("dep ex_read_data2", ex_read_data2, 32'h0000_BEEF);
    check("dep stall", {31'd0, stall}, 32'd0);
    memwb_reg_write = 1'b1; memwb_write_reg = 5'd9;
    #1;
    check("dep fwd_b memwb", {30'd0, forward_b}, 32'b01);
    memwb_reg_write = 1'b0;

    // Back-to-back loads stall independently
    drive_load_9();
    tick();
    id_write_reg = 5'd12; id_rs = 5'd9; id_rt = 5'd1;
    #1;
    check("b2b stall 1", {31'd0, stall}, 32'd1);
    tick();
    check("b2b bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    check("b2b second load", {27'd0, ex_write_reg}, 32'd12);
    id_mem_read = 1'b0; id_rs = 5'd12; id_rt = 5'd2; id_write_reg = 5'd13;
    #1;
    check("b2b stall 2", {31'd0, stall}, 32'd1);
    tick();
    check("b2b bubble 2", {31'd0, ex_mem_read}, 32'd0);

    // Flush suppresses stall
    drive_load_9();
    tick();
    drive_dependent();
    flush = 1'b1;
    #1;
    check("flush stall", {31'd0, stall}, 32'd0);
    tick();
    check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
    check("flush ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    flush = 1'b0;

    // Reset during stall
    drive_load_9();
    tick();
    drive_dependent();
    memwb_reg_write = 1'b1; memwb_write_reg = 5'd5;
    #1;
    check("pre-reset stall", {31'd0, stall}, 32'd1);
    check("pre-reset fwd_b", {30'd0, forward_b}, 32'b01);
    reset = 1'b0;
    tick();
    check_all_zero("reset-in-stall");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register for the pipelined MIPS core.
- Also generates the load-use stall and the 2-bit operand-forwarding selectors.
- forward_a/forward_b drive the Selector inputs of the two EX-stage 3-to-1 operand multiplexers.
- ex_read_data1/ex_read_data2 feed those multiplexers' Data0 inputs.

Parameters:
NBits, 32, datapath width
CTRL_W, 8, width of opaque EX/MEM/WB control bundle carried through

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
flush  input  1  kill ID instruction (taken branch/jump)
id_valid  input  1  ID stage holds a real instruction
id_rs  input  5  source register 1 number
id_rt  input  5  source register 2 number
id_write_reg  input  5  destination register (after RegDst)
id_read_data1  input  NBits  register file port 1
id_read_data2  input  NBits  register file port 2
id_imm  input  NBits  sign-extended immediate
id_ctrl  input  CTRL_W  control bundle
id_reg_write  input  1  instruction writes register file
id_mem_read  input  1  instruction is a load
exmem_reg_write  input  1  EX/MEM writes register file
exmem_write_reg  input  5  EX/MEM destination
memwb_reg_write  input  1  MEM/WB writes register file
memwb_write_reg  input  5  MEM/WB destination
ex_valid, ex_rs, ex_rt, ex_write_reg, ex_read_data1, ex_read_data2, ex_imm, ex_ctrl, ex_reg_write, ex_mem_read  output  (widths as ID counterparts)  registered EX-stage copies
forward_a  output  2  selector for ALU operand A mux
forward_b  output  2  selector for ALU operand B mux
stall  output  1  hold PC and IF/ID; combinational

Behaviour:
- Reset and polarity:
  - Reset is synchronous and active-low.
  - One clock, clk, named clk; the reset port is named reset.
  - While reset==0 at a rising edge, all registered outputs clear to 0.
  - forward_a, forward_b and stall therefore also evaluate to 0.
- Register update priority at each edge: reset > flush > stall > load.
  - Load: all ex_* outputs take their id_* values. Latency is 1 cycle.
  - Flush or stall (bubble): every ex_* output clears to 0, the same as reset.
- Hazard:
  - hazard = ex_valid & ex_mem_read & (ex_write_reg!=0) & id_valid & (ex_write_reg==id_rs | ex_write_reg==id_rt).
  - stall = hazard & ~flush, so flush suppresses stall.
  - The inserted bubble clears ex_mem_read, so stall lasts exactly 1 cycle per load-use pair.
  - Back-to-back loads each stall independently.
- forward_a is combinational from the registered ex_rs:
  - 2'b10 if ex_valid & exmem_reg_write & exmem_write_reg!=0 & exmem_write_reg==ex_rs.
  - else 2'b01 if ex_valid & memwb_reg_write & memwb_write_reg!=0 & memwb_write_reg==ex_rs.
  - else 2'b00.
- forward_b is identical to forward_a, using ex_rt.
- When EX/MEM and MEM/WB both match, EX/MEM (2'b10, the newest value) wins.
- Encoding 2'b11 is never produced.
- $0 is never forwarded.
- Reset mid-stall: the next edge clears everything and stall drops immediately.

Decomposition:
- Shared package holds:
  - FWD_REGFILE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - REG_ADDR_W=5.
  - The CTRL_W default.
- One sub-module is natural: forward_select, the combinational comparator that produces one 2-bit selector.
  - It is instantiated twice, once with ex_rs and once with ex_rt.

Test Plan:
- Reset, plain load:
  - Stimulus: hold reset=0 for 2 cycles with id_* nonzero, then release and load id_read_data1=32'h1234.
  - Required: all outputs 0 during reset; ex_read_data1=32'h1234 exactly one edge after release.
- EX/MEM forwarding:
  - Stimulus: ex_rs=8, exmem_reg_write=1, exmem_write_reg=8.
  - Required: forward_a=2'b10.
  - Add memwb_write_reg=8, memwb_reg_write=1: forward_a stays 2'b10.
  - Drop exmem_reg_write: forward_a becomes 2'b01.
- Register $0:
  - Stimulus: ex_rt=0, exmem_write_reg=0, exmem_reg_write=1.
  - Required: forward_b=2'b00.
- Load-use:
  - Stimulus: EX holds lw with ex_write_reg=9; ID has id_rt=9.
  - Required: stall=1 for exactly 1 cycle; next cycle ex_valid=0 and ex_ctrl=0; the following edge loads the dependent instruction.
  - Then with MEM/WB holding 9: forward_b=2'b01.
- Flush vs stall:
  - Stimulus: same hazard as the load-use case with flush=1.
  - Required: stall=0; next cycle ex_valid=0.
- Reset during stall:
  - Stimulus: assert reset=0 while stall=1.
  - Required: after the edge all outputs 0 and stall=0.
